// File: rtl/vec_load_unit_if.sv
// vec_load_unit_if: load request, memory read port and register file write port of the load unit
interface vec_load_unit_if #(
  parameter int LANES  = 6,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              scalar;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        stride;
  logic [3:0]        dest;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [7:0]        mem_rdata;
  logic              mem_valid;
  logic [LANES*8-1:0] wd3;
  logic              we3;
  logic [3:0]        a3;
  logic              sflag_o;
  logic              busy;
  logic              err;
  modport slave (
    input  start, scalar, base_addr, stride, dest, mem_rdata, mem_valid,
    output mem_addr, mem_req, wd3, we3, a3, sflag_o, busy, err
  );
  modport master (
    output start, scalar, base_addr, stride, dest, mem_rdata, mem_valid,
    input  mem_addr, mem_req, wd3, we3, a3, sflag_o, busy, err
  );
endinterface

// File: rtl/vec_load_unit.sv
// vec_load_unit: strided byte gather from data memory into one register file write
module vec_load_unit #(
  parameter int LANES  = 6,
  parameter int ADDR_W = 16
) (
  input logic          clk,
  input logic          rst,
  vec_load_unit_if.slave bus
);
  localparam int LW = LANES * 8;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;
  state_t            state_q;
  logic              scalar_q, req_q, we3_q, err_q, busy_q, sflag_q;
  logic [7:0]        stride_q;
  logic [3:0]        dest_q, a3_q;
  logic [IW-1:0]     idx_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     buf_q, buf_d, wd3_q;
  logic              legal_d, last_d;
  always_comb begin
    legal_d = bus.scalar ? (32'(bus.dest) < LANES) : (bus.dest != 4'd0 && bus.dest <= 4'd9);
    last_d  = idx_q == (scalar_q ? '0 : LAST);
    buf_d   = buf_q | (LW'(bus.mem_rdata) << {idx_q, 3'b000});
    addr_d  = addr_q + ADDR_W'(stride_q);
  end
  // mem_addr is kept as a running sum so lane k sits at base + k*stride with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      scalar_q <= 1'b0;
      stride_q <= '0;
      dest_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      buf_q    <= '0;
      req_q    <= 1'b0;
      we3_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      sflag_q  <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
    end else begin
      req_q <= 1'b0;
      we3_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          if (legal_d) begin
            state_q  <= REQ;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            scalar_q <= bus.scalar;
            stride_q <= bus.stride;
            dest_q   <= bus.dest;
            addr_q   <= bus.base_addr;
            buf_q    <= '0;
            idx_q    <= '0;
          end else err_q <= 1'b1;
        end
        REQ: state_q <= WAIT;
        WAIT: if (bus.mem_valid) begin
          buf_q <= buf_d;
          if (last_d) begin
            state_q <= WRITE;
            we3_q   <= 1'b1;
            wd3_q   <= buf_d;
            a3_q    <= dest_q;
            sflag_q <= scalar_q;
          end else begin
            state_q <= REQ;
            req_q   <= 1'b1;
            idx_q   <= idx_q + 1'b1;
            addr_q  <= addr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end
  assign bus.mem_addr = addr_q;
  assign bus.mem_req  = req_q;
  assign bus.wd3      = wd3_q;
  assign bus.we3      = we3_q;
  assign bus.a3       = a3_q;
  assign bus.sflag_o  = sflag_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_vec_load_unit.sv
// tb_vec_load_unit: randomized loads against a queue-based scoreboard and a behavioural memory
module tb_vec_load_unit;
  localparam int LANES = 6;
  typedef struct {
    logic [47:0] wd3;
    logic [3:0]  a3;
    logic        sf;
    int          n;
  } wexp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, start_cyc = 0, checks = 0, errors = 0, lat = 1, err_pend = 0;
  logic stray_en = 1'b0;
  logic [7:0] mem [65536];
  wexp_t wq[$];
  logic [15:0] aq[$];
  vec_load_unit_if #(.LANES(LANES), .ADDR_W(16)) bus();
  vec_load_unit #(.LANES(LANES), .ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // memory: answers each request L cycles later, optionally with a stray strobe in the REQ cycle
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        logic [15:0] a;
        a = bus.mem_addr;
        if (stray_en) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = 8'hEE;
        end
        @(posedge clk);
        #1 bus.mem_valid = 1'b0;
        repeat (lat - 1) @(posedge clk);
        #1 bus.mem_valid = 1'b1;
        bus.mem_rdata = mem[a];
        @(posedge clk);
        #1 bus.mem_valid = 1'b0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req) begin
        if (aq.size() == 0) chk("unexpected_mem_req", 1, 0);
        else chk("mem_addr", bus.mem_addr, aq.pop_front());
      end
      if (!rst && bus.we3) begin
        if (wq.size() == 0) chk("unexpected_we3", 1, 0);
        else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wd3", bus.wd3, e.wd3);
          chk("a3", bus.a3, e.a3);
          chk("sflag", bus.sflag_o, e.sf);
          chk("we3_cycle", cyc - start_cyc + 1, e.n);
        end
      end
      if (!rst && bus.err) begin
        if (err_pend == 0) chk("unexpected_err", 1, 0);
        else begin
          err_pend--;
          chk("err_cycle", cyc - start_cyc + 1, 1);
        end
      end
    end
  end
  task automatic do_load(input logic sc, input logic [15:0] base, input logic [7:0] st,
                         input logic [3:0] d, input int l);
    int nl;
    logic legal;
    logic [47:0] w;
    legal = sc ? (int'(d) < LANES) : (d >= 1 && d <= 9);
    nl = sc ? 1 : LANES;
    lat = l;
    w = '0;
    if (legal) begin
      for (int k = 0; k < nl; k++) begin
        logic [15:0] a;
        a = 16'((int'(base) + k * int'(st)) % 65536);
        aq.push_back(a);
        w[8*k +: 8] = mem[a];
      end
      wq.push_back('{wd3: w, a3: d, sf: sc, n: 1 + nl * (1 + l)});
    end else err_pend++;
    @(negedge clk);
    bus.scalar = sc;
    bus.base_addr = base;
    bus.stride = st;
    bus.dest = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    bus.start = 1'b0;
    bus.scalar = 1'($urandom);
    bus.base_addr = 16'($urandom);
    bus.stride = 8'($urandom);
    bus.dest = 4'($urandom);
    if (!legal) begin
      @(negedge clk);
      chk("busy_after_illegal", bus.busy, 0);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 400);
    chk("idle_reached", bus.busy, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_mem_req"}, bus.mem_req, 0);
    chk({nm, "_mem_addr"}, bus.mem_addr, 0);
    chk({nm, "_we3"}, bus.we3, 0);
    chk({nm, "_err"}, bus.err, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_a3"}, bus.a3, 0);
    chk({nm, "_sflag"}, bus.sflag_o, 0);
    chk({nm, "_wd3"}, bus.wd3, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.scalar = 1'b0;
    bus.base_addr = '0;
    bus.stride = '0;
    bus.dest = '0;
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    mem[16'h0040] = 8'hAB;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;
    do_load(1'b0, 16'h0010, 8'd1, 4'd6, 1);
    wait_idle();
    do_load(1'b1, 16'h0040, 8'd5, 4'd3, 1);
    wait_idle();
    do_load(1'b0, 16'hFFFE, 8'd2, 4'd2, 3);
    wait_idle();
    do_load(1'b0, 16'h0100, 8'd1, 4'd0, 1);
    wait_idle();
    do_load(1'b1, 16'h0100, 8'd1, 4'd7, 1);
    wait_idle();
    stray_en = 1'b1;
    do_load(1'b0, 16'h0200, 8'd3, 4'd9, 1);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1;
    bus.dest = 4'd0;
    bus.scalar = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();
    stray_en = 1'b0;
    do_load(1'b0, 16'h0300, 8'd7, 4'd4, 3);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("midreset");
    wq.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    do_load(1'b0, 16'h0400, 8'd1, 4'd5, 1);
    wait_idle();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 24; t++) begin
      logic sc;
      logic [3:0] d;
      sc = ($urandom_range(3) == 0);
      d = ($urandom_range(6) == 0) ? 4'($urandom) : (sc ? 4'($urandom_range(LANES - 1)) : 4'($urandom_range(9, 1)));
      do_load(sc, 16'($urandom), 8'($urandom), d, $urandom_range(3, 1));
      wait_idle();
    end
    repeat (10) @(posedge clk);
    chk("we3_queue_empty", wq.size(), 0);
    chk("addr_queue_empty", aq.size(), 0);
    chk("err_pending", err_pend, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Multi-cycle vector/scalar load engine that gathers bytes from the byte-wide data memory and writes them back to the vector register file in a single write cycle. It sits directly upstream of the register file write port: its `wd3`, `we3`, `a3` and `sflag_o` outputs drive the register file's WD3, WE3, A3 and SFlag inputs during a load. One load is in flight at a time. The block issues one memory request per lane, with one outstanding request and a strided address.

## Interface
- `LANES`, default 6: number of 8-bit lanes per vector register.
- `ADDR_W`, default 16: data memory address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: load request; sampled only in IDLE.
- `scalar` input 1: 1 = scalar load (one byte into scalar register), 0 = vector load.
- `base_addr` input ADDR_W: address of lane 0.
- `stride` input 8: unsigned byte stride between lanes.
- `dest` input 4: destination register index.
- `mem_addr` output ADDR_W: memory read address.
- `mem_req` output 1: one-cycle read request.
- `mem_rdata` input 8: read data, valid with `mem_valid`.
- `mem_valid` input 1: read data strobe.
- `wd3` output LANES×8: assembled vector; lane i occupies bits [8i+7:8i].
- `we3` output 1: register file write enable, one-cycle pulse.
- `a3` output 4: register file destination index.
- `sflag_o` output 1: scalar flag to register file.
- `busy` output 1: high in every state except IDLE.
- `err` output 1: one-cycle pulse on rejected start.

## Operation
- **Reset values:**
  - States: IDLE.
  - Outputs: `mem_req`=0, `mem_addr`=0, `we3`=0, `err`=0, `busy`=0, `a3`=0, `sflag_o`=0, `wd3`=0.
  - Internal: lane counter=0, lane buffer=0.
- **Start and operand capture:** on `start` in IDLE, the block latches `scalar`, `base_addr`, `stride` and `dest`. Later changes to these inputs have no effect on the load in progress.
- **Destination check:**
  - Scalar loads require `dest` ≤ LANES-1.
  - Vector loads require 1 ≤ `dest` ≤ 9. Index 0 is the scalar bank.
  - An illegal `dest` pulses `err` for 1 cycle, the FSM stays in IDLE, and no memory access occurs.
- **Lane buffer clear:** the lane buffer is cleared on every accepted start. Lanes that are not loaded are 0.
- **State machine:**
  - IDLE → REQ on a legal start.
  - REQ: assert `mem_req` for exactly 1 cycle with `mem_addr` = base + idx×stride, computed modulo 2^ADDR_W (wraps). Then → WAIT.
  - WAIT: hold until `mem_valid` is sampled high. Write `mem_rdata` into lane idx.
    - If idx = last lane → WRITE.
    - Otherwise idx+1 → REQ.
    - The last lane is lane 0 for scalar loads and lane LANES-1 for vector loads.
  - WRITE: `we3`=1 for 1 cycle, with `a3`=latched dest, `sflag_o`=latched scalar, and `wd3`=buffer. Then → IDLE and clear the lane counter.
- **Scalar loads:** `wd3` lane 0 carries the byte. The register file selects the scalar slot via `a3`.
- **Stray `mem_valid`:** `mem_valid` outside WAIT is ignored. A second `mem_valid` in the same WAIT cannot occur, because the FSM leaves WAIT on the first.
- **`start` while busy:** ignored. No queueing and no `err`.
- **Output hold:** `wd3`, `a3` and `sflag_o` hold their last values outside WRITE. Only `we3` qualifies them.
- **Reset mid-operation:** everything returns immediately to reset values. No `we3` is issued, even if reset lands in WRITE. Any late `mem_valid` after reset is ignored.

## Timing
- `start` is sampled at edge E0. The first REQ cycle follows E0.
- Lane k costs 1 REQ cycle plus L cycles, where L ≥ 1 is the count up to and including the cycle in which `mem_valid` is sampled.
- **Vector load:** `we3` is high in cycle 1 + LANES×(1+L) after E0. With L=1 and LANES=6, that is cycle 13.
- **Scalar load:** `we3` is high in cycle 1 + (1+L). With L=1, that is cycle 3.
- `busy` rises the cycle after E0 and falls the cycle after WRITE.
- A new `start` is accepted in the first IDLE cycle after WRITE.
- `err` is high in the cycle after E0.
- No combinational path from `start` or `mem_valid` to any output; all outputs are registered.

## Test plan
- **Vector load:** base=0x0010, stride=1, dest=6, memory returns addr[7:0] with L=1.
  - Addresses 0x10..0x15 are requested.
  - `we3` is high in cycle 13, `a3`=6, `sflag_o`=0, `wd3` = 15 14 13 12 11 10 (hex, lane5..lane0).
- **Scalar load:** scalar=1, dest=3, base=0x0040, memory byte 0xAB.
  - One request only.
  - `we3` in cycle 3, `a3`=3, `sflag_o`=1, `wd3` = 0x0000000000AB.
- **Wrap and latency:** base=0xFFFE, stride=2, L=3.
  - Addresses 0xFFFE, 0x0000, 0x0002, 0x0004, 0x0006, 0x0008.
  - `we3` in cycle 25.
- **Illegal destination:** start with scalar=0, dest=0, then with scalar=1, dest=7 (the scalar range is 0..5).
  - `err` pulses each time.
  - `mem_req` and `we3` never assert and `busy` stays 0.
- **Busy, stray and reset:**
  - A second `start` during lane 2 is ignored.
  - A stray `mem_valid` in a REQ cycle does not advance the lane.
  - Asserting `rst` while in WAIT for lane 4 gives all outputs 0 in the same cycle, with no `we3` afterwards.
  - After reset, a new load completes normally.
